mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: C (the multicycle CPU's memory port) and D (the loader/debug DMA port).
- Accepts one request at a time and latches address, write enable and write data.
- Drives the memory for one access cycle, waits out the fixed read latency and returns registered read data to the winner.
- Sits between the CPU datapath/controller and the memory model; it replaces the direct CPU-to-memory connection.

Parameters:
- WIDTH, 32, data bus width.
- ADDR_W, 32, address width.
- LAT, 2, memory read latency in cycles from the m_en cycle to valid m_rdata; legal range ≥1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the next clk edge).
- c_req  in  1  CPU request; held high until c_gnt.
- c_we  in  1  CPU write enable (1=write, 0=read).
- c_addr  in  ADDR_W  CPU address.
- c_wdata  in  WIDTH  CPU write data.
- c_gnt  out  1  CPU request accepted this cycle.
- c_rvalid  out  1  one-cycle pulse: c_rdata valid.
- c_rdata  out  WIDTH  CPU read data, registered, held until the next C read completes.
- d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata: same as the C set, for port D.
- m_en  out  1  memory access strobe.
- m_we  out  1  memory write enable.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  WIDTH  memory write data.
- m_rdata  in  WIDTH  memory read data, valid LAT cycles after the m_en cycle.

Behaviour:
- FSM states: IDLE, ACCESS, WAIT. State register, owner bit, last-served bit and latched request (addr/we/wdata) are all updated on the clk rising edge.
- IDLE:
  - If any request is present, select a winner, assert its gnt combinationally in that cycle, and latch its addr/we/wdata at the edge. Owner is set to the winner; next state is ACCESS.
  - With no request: gnts stay 0 and the FSM stays in IDLE.
  - gnt is never asserted outside IDLE and never while reset==0.
- Arbitration:
  - One request present: that requester wins.
  - Both present: the requester not recorded in last-served wins (round-robin).
  - last-served is updated on each grant and resets to D, so C wins the first contention after reset.
- ACCESS (exactly one cycle):
  - m_en=1; m_we/m_addr/m_wdata come from the latched request.
  - Write: next state is IDLE; no rvalid is generated.
  - Read: load the counter with LAT-1; next state is WAIT.
- WAIT:
  - m_en=0; counter decrements each cycle.
  - When the counter reaches 0, m_rdata is captured into the owner's rdata register at the edge, the owner's rvalid pulses high for the following cycle, and next state is IDLE.
- Outside ACCESS: m_en=0 and m_we=0. m_addr/m_wdata hold the latched values.
- Latency, with grant in cycle g:
  - m_en in g+1.
  - Read rvalid in g+LAT+2.
  - A new grant is possible in g+2 (write) or g+LAT+2 (read); the rvalid cycle is also an IDLE cycle.
- Counter width: enough bits to hold LAT-1; LAT=1 means WAIT lasts a single cycle.
- The non-owner's rdata and rvalid are never disturbed.
- A requester that drops req without gnt is simply not served. A request arriving during ACCESS/WAIT waits; there is no queueing beyond the req level.
- Reset values: state=IDLE, last-served=D, m_en=0, m_we=0, m_addr=0, m_wdata=0, c/d_rvalid=0, c/d_rdata=0, c/d_gnt=0.
- Reset mid-operation: the in-flight transaction is abandoned, no rvalid is issued, and m_en is 0 from the cycle after the reset edge. A write in ACCESS during the reset cycle still reaches the memory that cycle.

Optional Feature:
- MEM_ARB_FIXED_PRIO_EN:
  - Defined: C always wins contention and last-served is ignored (D is served only when c_req=0).
  - Undefined: round-robin as above.
  - All other timing is identical in both modes.

Test Plan:
- Reset, then C read addr 0x10, memory word 0xCAFE0001, LAT=2 → c_gnt in cycle g, m_en/m_addr=0x10 in g+1, c_rvalid and c_rdata=0xCAFE0001 in g+4; d_rvalid stays 0.
- D write addr 0x20 data 0x12345678 → d_gnt in g, then m_en=1, m_we=1, m_addr=0x20, m_wdata=0x12345678 in g+1; IDLE in g+2; no rvalid.
- c_req and d_req both held high continuously, all writes → grants alternate C, D, C, D (C first after reset), one grant every 2 cycles. With MEM_ARB_FIXED_PRIO_EN defined → C granted every time and D never.
- C read in progress (WAIT) when d_req rises → d_gnt only in the IDLE cycle coinciding with c_rvalid; d_rdata unchanged by the C read.
- Reset driven to 0 in the WAIT cycle of a C read → after the edge: state IDLE, c_rvalid never pulses, m_en=0, all gnts 0 while reset=0.
- LAT=1 build, back-to-back C reads of 0x4 then 0x8 → rvalid 3 cycles after each grant; second grant in the cycle of the first c_rvalid.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
// ---------------------------------------------------------------------------
// Shares one single-ported memory between two requesters: C (CPU memory
// port) and D (loader/debug DMA port). One request is accepted at a time. Its
// address, write enable and write data are latched. The memory is driven for
// one access cycle. The arbiter then waits out the fixed read latency and
// returns registered read data to the requester that won.
//
// Ports
//   clk                 rising-edge clock
//   reset               synchronous, active-low reset
//   c_req/c_we/c_addr/c_wdata   CPU request (req held until c_gnt)
//   c_gnt               CPU request accepted this cycle (combinational, IDLE only)
//   c_rvalid/c_rdata    one-cycle read-complete pulse / held read data
//   d_*                 same set for the DMA port
//   m_en/m_we/m_addr/m_wdata    memory access strobe and latched request
//   m_rdata             memory read data, valid LAT cycles after the m_en cycle
//
// Parameters
//   WIDTH   data bus width
//   ADDR_W  address width
//   LAT     memory read latency in cycles (>= 1)
//
// Build option
//   MEM_ARB_FIXED_PRIO_EN  when defined, C always wins contention;
//                          otherwise contention is resolved round-robin.
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [WIDTH-1:0]  c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [WIDTH-1:0]  c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WIDTH-1:0]  d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [WIDTH-1:0]  d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [WIDTH-1:0]  m_wdata,
    input  logic [WIDTH-1:0]  m_rdata
);

    // Enough bits to hold LAT-1; a single bit when LAT is 1.
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                win_d_s;        // 1: D wins this IDLE cycle
    logic                owner_r;        // 0: C, 1: D
    logic                last_served_r;  // 0: C, 1: D
    logic                lat_we_r;
    logic [ADDR_W-1:0]   lat_addr_r;
    logic [WIDTH-1:0]    lat_wdata_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                rd_done_s;
    logic                c_rvalid_r;
    logic                d_rvalid_r;
    logic [WIDTH-1:0]    c_rdata_r;
    logic [WIDTH-1:0]    d_rdata_r;

    // Last latency cycle of a read: data is captured at the end of this cycle.
    assign rd_done_s = (state_r == WAIT) && (cnt_r == {CNT_W{1'b0}});

    // Next-state logic, arbitration and combinational grants.
    always_comb begin
        state_s = state_r;
        win_d_s = 1'b0;
        c_gnt   = 1'b0;
        d_gnt   = 1'b0;
        case (state_r)
            IDLE: begin
                // Grants are suppressed while reset is held low.
                if (reset && (c_req || d_req)) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                    win_d_s = !c_req;
`else
                    // Under contention D wins only if C was served last.
                    win_d_s = !c_req || (d_req && !last_served_r);
`endif
                    c_gnt   = !win_d_s;
                    d_gnt   = win_d_s;
                    state_s = ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (lat_we_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            WAIT: begin
                if (rd_done_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register, owner/last-served tracking and request latch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= IDLE;
            owner_r       <= 1'b0;
            last_served_r <= 1'b1;
            lat_we_r      <= 1'b0;
            lat_addr_r    <= {ADDR_W{1'b0}};
            lat_wdata_r   <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            if (c_gnt || d_gnt) begin
                owner_r       <= d_gnt;
                last_served_r <= d_gnt;
                lat_we_r      <= d_gnt ? d_we    : c_we;
                lat_addr_r    <= d_gnt ? d_addr  : c_addr;
                lat_wdata_r   <= d_gnt ? d_wdata : c_wdata;
            end
        end
    end

    // Read latency counter: loaded in ACCESS for reads, counts down in WAIT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ACCESS) && !lat_we_r) begin
            cnt_r <= CNT_W'(LAT - 1);
        end else if ((state_r == WAIT) && !rd_done_s) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end
    end

    // Read-data capture into the owner's registers; the other port is untouched.
    always_ff @(posedge clk) begin
        if (!reset) begin
            c_rvalid_r <= 1'b0;
            d_rvalid_r <= 1'b0;
            c_rdata_r  <= {WIDTH{1'b0}};
            d_rdata_r  <= {WIDTH{1'b0}};
        end else begin
            c_rvalid_r <= rd_done_s && !owner_r;
            d_rvalid_r <= rd_done_s && owner_r;
            if (rd_done_s && !owner_r) begin
                c_rdata_r <= m_rdata;
            end
            if (rd_done_s && owner_r) begin
                d_rdata_r <= m_rdata;
            end
        end
    end

    // Memory side is decoded from registered state only. The address and data
    // hold their latched values between accesses.
    assign m_en     = (state_r == ACCESS);
    assign m_we     = (state_r == ACCESS) && lat_we_r;
    assign m_addr   = lat_addr_r;
    assign m_wdata  = lat_wdata_r;
    assign c_rvalid = c_rvalid_r;
    assign d_rvalid = d_rvalid_r;
    assign c_rdata  = c_rdata_r;
    assign d_rdata  = d_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter. It drives a LAT=2 instance (dut) and a
// LAT=1 instance (dut1). Each instance has its own behavioural memory, which
// is preloaded while reset is low. Inputs change 1 time unit after the rising
// edge. Outputs are checked on the falling edge.
module tb_mem_arbiter;

`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic c_gnt, c_rvalid, d_gnt, d_rvalid, m_en, m_we;
    logic [31:0] c_rdata, d_rdata, m_addr, m_wdata, m_rdata;

    logic c1_req, c1_we, d1_req, d1_we;
    logic [31:0] c1_addr, c1_wdata, d1_addr, d1_wdata;
    logic c1_gnt, c1_rvalid, d1_gnt, d1_rvalid, m1_en, m1_we;
    logic [31:0] c1_rdata, d1_rdata, m1_addr, m1_wdata, m1_rdata;

    logic [31:0] mem  [0:255];
    logic [31:0] pipe [0:1];
    logic [31:0] mem1 [0:255];

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(32), .ADDR_W(32), .LAT(2)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    mem_arbiter #(.WIDTH(32), .ADDR_W(32), .LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .c_req(c1_req), .c_we(c1_we), .c_addr(c1_addr), .c_wdata(c1_wdata),
        .c_gnt(c1_gnt), .c_rvalid(c1_rvalid), .c_rdata(c1_rdata),
        .d_req(d1_req), .d_we(d1_we), .d_addr(d1_addr), .d_wdata(d1_wdata),
        .d_gnt(d1_gnt), .d_rvalid(d1_rvalid), .d_rdata(d1_rdata),
        .m_en(m1_en), .m_we(m1_we), .m_addr(m1_addr), .m_wdata(m1_wdata),
        .m_rdata(m1_rdata)
    );

    // Memory with a two-stage read pipe: data is valid 2 cycles after m_en.
    always @(posedge clk) begin
        if (!reset) begin
            mem[8'h10] <= 32'hCAFE0001;
        end else if (m_en && m_we) begin
            mem[m_addr[7:0]] <= m_wdata;
        end
        if (m_en && !m_we) pipe[0] <= mem[m_addr[7:0]];
        pipe[1] <= pipe[0];
    end
    assign m_rdata = pipe[1];

    // Memory with a one-stage read pipe for the LAT=1 instance.
    always @(posedge clk) begin
        if (!reset) begin
            mem1[8'h04] <= 32'h11110004;
            mem1[8'h08] <= 32'h22220008;
        end else if (m1_en && m1_we) begin
            mem1[m1_addr[7:0]] <= m1_wdata;
        end
        if (m1_en && !m1_we) m1_rdata <= mem1[m1_addr[7:0]];
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; c_req = 1'b1; d_req = 1'b1; c_we = 1'b0; d_we = 1'b0;
        cyc(); cyc();
        @(negedge clk);
        n_checks++; if (c_gnt !== 1'b0)    begin n_fail++; $display("FAIL rst_c_gnt: got %b want 0", c_gnt); end
        n_checks++; if (d_gnt !== 1'b0)    begin n_fail++; $display("FAIL rst_d_gnt: got %b want 0", d_gnt); end
        n_checks++; if (m_en !== 1'b0)     begin n_fail++; $display("FAIL rst_m_en: got %b want 0", m_en); end
        n_checks++; if (m_we !== 1'b0)     begin n_fail++; $display("FAIL rst_m_we: got %b want 0", m_we); end
        n_checks++; if (m_addr !== 32'h0)  begin n_fail++; $display("FAIL rst_m_addr: got %h want 0", m_addr); end
        n_checks++; if (m_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_m_wdata: got %h want 0", m_wdata); end
        n_checks++; if (c_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_c_rvalid: got %b want 0", c_rvalid); end
        n_checks++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_d_rvalid: got %b want 0", d_rvalid); end
        n_checks++; if (c_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_c_rdata: got %h want 0", c_rdata); end
        n_checks++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_d_rdata: got %h want 0", d_rdata); end
        cyc();
        reset = 1'b1; c_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_c_read();
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
        @(negedge clk);
        n_checks++; if (c_gnt !== 1'b1) begin n_fail++; $display("FAIL crd_gnt: got %b want 1", c_gnt); end
        n_checks++; if (d_gnt !== 1'b0) begin n_fail++; $display("FAIL crd_dgnt: got %b want 0", d_gnt); end
        n_checks++; if (m_en !== 1'b0)  begin n_fail++; $display("FAIL crd_men_g: got %b want 0", m_en); end
        cyc(); c_req = 1'b0; c_addr = 32'h0;
        @(negedge clk);
        n_checks++; if (m_en !== 1'b1)    begin n_fail++; $display("FAIL crd_men: got %b want 1", m_en); end
        n_checks++; if (m_we !== 1'b0)    begin n_fail++; $display("FAIL crd_mwe: got %b want 0", m_we); end
        n_checks++; if (m_addr !== 32'h10) begin n_fail++; $display("FAIL crd_maddr: got %h want 10", m_addr); end
        cyc();
        @(negedge clk);
        n_checks++; if (m_en !== 1'b0)     begin n_fail++; $display("FAIL crd_men_wait: got %b want 0", m_en); end
        n_checks++; if (c_rvalid !== 1'b0) begin n_fail++; $display("FAIL crd_rv_g2: got %b want 0", c_rvalid); end
        cyc();
        @(negedge clk);
        n_checks++; if (c_rvalid !== 1'b0) begin n_fail++; $display("FAIL crd_rv_g3: got %b want 0", c_rvalid); end
        cyc();
        @(negedge clk);
        n_checks++; if (c_rvalid !== 1'b1)       begin n_fail++; $display("FAIL crd_rv_g4: got %b want 1", c_rvalid); end
        n_checks++; if (c_rdata !== 32'hCAFE0001) begin n_fail++; $display("FAIL crd_rdata: got %h want cafe0001", c_rdata); end
        n_checks++; if (d_rvalid !== 1'b0)       begin n_fail++; $display("FAIL crd_drv: got %b want 0", d_rvalid); end
        cyc();
        @(negedge clk);
        n_checks++; if (c_rvalid !== 1'b0)       begin n_fail++; $display("FAIL crd_rv_g5: got %b want 0", c_rvalid); end
        n_checks++; if (c_rdata !== 32'hCAFE0001) begin n_fail++; $display("FAIL crd_rdata_hold: got %h want cafe0001", c_rdata); end
        cyc();
    endtask

    task automatic test_d_write();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678;
        @(negedge clk);
        n_checks++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL dwr_gnt: got %b want 1", d_gnt); end
        n_checks++; if (c_gnt !== 1'b0) begin n_fail++; $display("FAIL dwr_cgnt: got %b want 0", c_gnt); end
        cyc(); d_req = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        @(negedge clk);
        n_checks++; if (m_en !== 1'b1)            begin n_fail++; $display("FAIL dwr_men: got %b want 1", m_en); end
        n_checks++; if (m_we !== 1'b1)            begin n_fail++; $display("FAIL dwr_mwe: got %b want 1", m_we); end
        n_checks++; if (m_addr !== 32'h20)        begin n_fail++; $display("FAIL dwr_maddr: got %h want 20", m_addr); end
        n_checks++; if (m_wdata !== 32'h12345678) begin n_fail++; $display("FAIL dwr_mwdata: got %h want 12345678", m_wdata); end
        cyc();
        // g+2 is IDLE again: a new C write is granted here.
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h30; c_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        n_checks++; if (m_en !== 1'b0)     begin n_fail++; $display("FAIL dwr_men_g2: got %b want 0", m_en); end
        n_checks++; if (m_we !== 1'b0)     begin n_fail++; $display("FAIL dwr_mwe_g2: got %b want 0", m_we); end
        n_checks++; if (m_addr !== 32'h20) begin n_fail++; $display("FAIL dwr_maddr_hold: got %h want 20", m_addr); end
        n_checks++; if (c_gnt !== 1'b1)    begin n_fail++; $display("FAIL dwr_idle_g2: got %b want 1", c_gnt); end
        n_checks++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL dwr_drv: got %b want 0", d_rvalid); end
        cyc(); c_req = 1'b0;
        @(negedge clk);
        n_checks++; if (m_addr !== 32'h30) begin n_fail++; $display("FAIL cwr_maddr: got %h want 30", m_addr); end
        n_checks++; if (m_we !== 1'b1)     begin n_fail++; $display("FAIL cwr_mwe: got %b want 1", m_we); end
        cyc();
        @(negedge clk);
        n_checks++; if (c_rvalid !== 1'b0) begin n_fail++; $display("FAIL cwr_crv: got %b want 0", c_rvalid); end
        n_checks++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL cwr_drv: got %b want 0", d_rvalid); end
        cyc();
    endtask

    task automatic test_round_robin();
        logic exp_c, exp_d;
        c_we = 1'b1; c_addr = 32'h40; c_wdata = 32'hC0C0C0C0;
        d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'hD0D0D0D0;
        for (int i = 0; i < 8; i++) begin
            c_req = 1'b1; d_req = 1'b1;
            exp_c = FIXED ? (i % 2 == 0) : (i % 4 == 0);
            exp_d = FIXED ? 1'b0 : (i % 4 == 2);
            @(negedge clk);
            n_checks++; if (c_gnt !== exp_c) begin n_fail++; $display("FAIL rr_c_gnt[%0d]: got %b want %b", i, c_gnt, exp_c); end
            n_checks++; if (d_gnt !== exp_d) begin n_fail++; $display("FAIL rr_d_gnt[%0d]: got %b want %b", i, d_gnt, exp_d); end
            cyc();
        end
        c_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_wait_contention();
        // Give d_rdata a known value first.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        @(negedge clk);
        n_checks++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL wc_dgnt0: got %b want 1", d_gnt); end
        cyc(); d_req = 1'b0;
        cyc(); cyc(); cyc();
        @(negedge clk);
        n_checks++; if (d_rvalid !== 1'b1)        begin n_fail++; $display("FAIL wc_drv0: got %b want 1", d_rvalid); end
        n_checks++; if (d_rdata !== 32'h12345678) begin n_fail++; $display("FAIL wc_drdata0: got %h want 12345678", d_rdata); end
        cyc();
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
        @(negedge clk);
        n_checks++; if (c_gnt !== 1'b1) begin n_fail++; $display("FAIL wc_cgnt: got %b want 1", c_gnt); end
        cyc(); c_req = 1'b0;
        cyc();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
        @(negedge clk);
        n_checks++; if (d_gnt !== 1'b0) begin n_fail++; $display("FAIL wc_dgnt_g2: got %b want 0", d_gnt); end
        cyc();
        @(negedge clk);
        n_checks++; if (d_gnt !== 1'b0) begin n_fail++; $display("FAIL wc_dgnt_g3: got %b want 0", d_gnt); end
        cyc();
        @(negedge clk);
        n_checks++; if (c_rvalid !== 1'b1)        begin n_fail++; $display("FAIL wc_crv: got %b want 1", c_rvalid); end
        n_checks++; if (c_rdata !== 32'hCAFE0001) begin n_fail++; $display("FAIL wc_crdata: got %h want cafe0001", c_rdata); end
        n_checks++; if (d_gnt !== 1'b1)           begin n_fail++; $display("FAIL wc_dgnt_g4: got %b want 1", d_gnt); end
        n_checks++; if (d_rvalid !== 1'b0)        begin n_fail++; $display("FAIL wc_drv_g4: got %b want 0", d_rvalid); end
        n_checks++; if (d_rdata !== 32'h12345678) begin n_fail++; $display("FAIL wc_drdata_keep: got %h want 12345678", d_rdata); end
        cyc(); d_req = 1'b0;
        cyc(); cyc(); cyc();
        @(negedge clk);
        n_checks++; if (d_rvalid !== 1'b1)        begin n_fail++; $display("FAIL wc_drv: got %b want 1", d_rvalid); end
        n_checks++; if (d_rdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL wc_drdata: got %h want a5a5a5a5", d_rdata); end
        n_checks++; if (c_rvalid !== 1'b0)        begin n_fail++; $display("FAIL wc_crv_d: got %b want 0", c_rvalid); end
        n_checks++; if (c_rdata !== 32'hCAFE0001) begin n_fail++; $display("FAIL wc_crdata_keep: got %h want cafe0001", c_rdata); end
        cyc();
    endtask

    task automatic test_reset_mid();
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
        @(negedge clk);
        n_checks++; if (c_gnt !== 1'b1) begin n_fail++; $display("FAIL rm_cgnt: got %b want 1", c_gnt); end
        cyc(); c_req = 1'b0;
        cyc();
        reset = 1'b0; c_req = 1'b1; d_req = 1'b1;
        @(negedge clk);
        n_checks++; if (c_gnt !== 1'b0) begin n_fail++; $display("FAIL rm_cgnt_r: got %b want 0", c_gnt); end
        n_checks++; if (d_gnt !== 1'b0) begin n_fail++; $display("FAIL rm_dgnt_r: got %b want 0", d_gnt); end
        cyc();
        @(negedge clk);
        n_checks++; if (m_en !== 1'b0)     begin n_fail++; $display("FAIL rm_men: got %b want 0", m_en); end
        n_checks++; if (c_rvalid !== 1'b0) begin n_fail++; $display("FAIL rm_crv_g3: got %b want 0", c_rvalid); end
        n_checks++; if (c_gnt !== 1'b0)    begin n_fail++; $display("FAIL rm_cgnt_idle: got %b want 0", c_gnt); end
        n_checks++; if (d_gnt !== 1'b0)    begin n_fail++; $display("FAIL rm_dgnt_idle: got %b want 0", d_gnt); end
        cyc();
        reset = 1'b1; d_req = 1'b0; c_req = 1'b1; c_we = 1'b1; c_addr = 32'h50; c_wdata = 32'h0BAD0050;
        @(negedge clk);
        n_checks++; if (c_gnt !== 1'b1)    begin n_fail++; $display("FAIL rm_idle_gnt: got %b want 1", c_gnt); end
        n_checks++; if (c_rvalid !== 1'b0) begin n_fail++; $display("FAIL rm_crv_g4: got %b want 0", c_rvalid); end
        n_checks++; if (c_rdata !== 32'h0) begin n_fail++; $display("FAIL rm_crdata: got %h want 0", c_rdata); end
        cyc(); c_req = 1'b0;
        @(negedge clk);
        n_checks++; if (c_rvalid !== 1'b0) begin n_fail++; $display("FAIL rm_crv_g5: got %b want 0", c_rvalid); end
        n_checks++; if (m_we !== 1'b1)     begin n_fail++; $display("FAIL rm_mwe: got %b want 1", m_we); end
        cyc();
        @(negedge clk);
        n_checks++; if (c_rvalid !== 1'b0) begin n_fail++; $display("FAIL rm_crv_g6: got %b want 0", c_rvalid); end
        cyc();
    endtask

    task automatic test_lat1_back_to_back();
        c1_req = 1'b1; c1_we = 1'b0; c1_addr = 32'h4;
        @(negedge clk);
        n_checks++; if (c1_gnt !== 1'b1) begin n_fail++; $display("FAIL l1_gnt0: got %b want 1", c1_gnt); end
        cyc(); c1_addr = 32'h8;
        @(negedge clk);
        n_checks++; if (c1_gnt !== 1'b0)    begin n_fail++; $display("FAIL l1_gnt_g1: got %b want 0", c1_gnt); end
        n_checks++; if (m1_en !== 1'b1)     begin n_fail++; $display("FAIL l1_men: got %b want 1", m1_en); end
        n_checks++; if (m1_addr !== 32'h4)  begin n_fail++; $display("FAIL l1_maddr: got %h want 4", m1_addr); end
        cyc();
        @(negedge clk);
        n_checks++; if (c1_gnt !== 1'b0)    begin n_fail++; $display("FAIL l1_gnt_g2: got %b want 0", c1_gnt); end
        n_checks++; if (c1_rvalid !== 1'b0) begin n_fail++; $display("FAIL l1_rv_g2: got %b want 0", c1_rvalid); end
        cyc();
        @(negedge clk);
        n_checks++; if (c1_rvalid !== 1'b1)       begin n_fail++; $display("FAIL l1_rv_g3: got %b want 1", c1_rvalid); end
        n_checks++; if (c1_rdata !== 32'h11110004) begin n_fail++; $display("FAIL l1_rdata0: got %h want 11110004", c1_rdata); end
        n_checks++; if (c1_gnt !== 1'b1)          begin n_fail++; $display("FAIL l1_gnt1: got %b want 1", c1_gnt); end
        cyc(); c1_req = 1'b0;
        @(negedge clk);
        n_checks++; if (c1_rvalid !== 1'b0) begin n_fail++; $display("FAIL l1_rv_g4: got %b want 0", c1_rvalid); end
        n_checks++; if (m1_addr !== 32'h8)  begin n_fail++; $display("FAIL l1_maddr1: got %h want 8", m1_addr); end
        cyc();
        @(negedge clk);
        n_checks++; if (c1_rvalid !== 1'b0) begin n_fail++; $display("FAIL l1_rv_g5: got %b want 0", c1_rvalid); end
        cyc();
        @(negedge clk);
        n_checks++; if (c1_rvalid !== 1'b1)       begin n_fail++; $display("FAIL l1_rv_g6: got %b want 1", c1_rvalid); end
        n_checks++; if (c1_rdata !== 32'h22220008) begin n_fail++; $display("FAIL l1_rdata1: got %h want 22220008", c1_rdata); end
        cyc();
    endtask

    initial begin
        reset = 1'b0;
        c_req = 1'b0; c_we = 1'b0; c_addr = 32'h0; c_wdata = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        c1_req = 1'b0; c1_we = 1'b0; c1_addr = 32'h0; c1_wdata = 32'h0;
        d1_req = 1'b0; d1_we = 1'b0; d1_addr = 32'h0; d1_wdata = 32'h0;
        test_reset();
        test_c_read();
        test_d_write();
        test_reset();
        test_round_robin();
        test_wait_contention();
        test_reset_mid();
        test_lat1_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
